mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Shares one unified memory bus between the fetch port (imem, read-only) and the MEM-stage LSU port (dmem, read/write).
- Sits between the pipeline's fetch/MEM stages and the memory controller.
- Registers the winning request, drives a single-outstanding bus transaction, and returns a one-cycle ready/rdata pulse to the owner.
- Converts bus latency into requester stalls (fetch stall, mem_stall), with a starvation guard and a timeout.

Parameters:
- XLEN, 32, data/address width (from riscv_pkg).
- MAX_STARVE, 4, consecutive dmem grants allowed while imem waits before imem is forced to win.
- TIMEOUT, 64, cycles to wait for bus_ack before aborting with an error.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- imem_req  in  1  fetch request, held until imem_ready.
- imem_addr  in  XLEN  fetch address.
- imem_rdata  out  XLEN  fetch data, valid with imem_ready.
- imem_ready  out  1  one-cycle completion pulse.
- imem_err  out  1  timeout flag, valid with imem_ready.
- dmem_rd_en  in  1  LSU read request.
- dmem_wr_en  in  1  LSU write request.
- dmem_addr  in  XLEN  LSU address.
- dmem_wdata  in  XLEN  LSU write data.
- dmem_byte_en  in  4  LSU byte enables.
- dmem_rdata  out  XLEN  load data, valid with dmem_ready.
- dmem_ready  out  1  one-cycle completion pulse.
- dmem_err  out  1  timeout flag, valid with dmem_ready.
- bus_req  out  1  transaction valid.
- bus_we  out  1  write strobe.
- bus_addr  out  XLEN  bus address.
- bus_wdata  out  XLEN  bus write data.
- bus_be  out  4  bus byte enables.
- bus_ack  in  1  one-cycle completion from controller.
- bus_rdata  in  XLEN  read data, valid with bus_ack.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; starve_cnt=0; timer=0.
  - All outputs are 0, including bus_req, ready and err pulses, and the data buses.
- States: IDLE, BUSY_I, BUSY_D.
- IDLE, arbitration each cycle:
  - dreq = dmem_rd_en | dmem_wr_en.
  - If dreq && !(imem_req && starve_cnt==MAX_STARVE): grant dmem.
  - Else if imem_req: grant imem.
  - Otherwise stay in IDLE.
- On grant:
  - Capture addr, wdata, be and we into registers at the clock edge.
  - For imem: we=0 and be=4'hF.
  - Go to BUSY_x.
  - bus_req rises the cycle after the request is seen, so minimum latency is request cycle + 1 cycle to bus_req.
- If dmem_wr_en and dmem_rd_en are both 1, the write takes precedence (we=1).
- BUSY_x:
  - bus_req=1; bus_addr/bus_wdata/bus_be/bus_we come from registers and stay stable until ack.
  - timer increments each cycle.
- bus_ack in BUSY_x:
  - x_ready=1 for that cycle, with x_rdata=bus_rdata (combinational passthrough) and x_err=0.
  - bus_req deasserts next cycle; state returns to IDLE, giving one bubble between transactions.
  - ready and rdata outputs are 0 when not pulsing.
- Timeout:
  - When timer reaches TIMEOUT-1 without ack: x_ready=1, x_err=1, x_rdata=0.
  - State goes to IDLE and bus_req drops.
  - A late bus_ack in IDLE is ignored.
- Starvation counter:
  - Increments (saturating at MAX_STARVE) on each dmem grant where imem_req=1.
  - Cleared on any imem grant.
  - Unchanged on a dmem grant where imem_req=0.
- Requester drops its request before grant: no effect; nothing is captured.
- Requester drops its request mid-transaction: the transaction completes on the bus anyway; the ready pulse is still issued (the requester ignores it).
- bus_ack with bus_req=0: ignored.
- Simultaneous imem_req and dreq with starve_cnt<MAX_STARVE: dmem wins. MEM is the older instruction, which avoids pipeline deadlock.
- Reset mid-transaction: the transaction is abandoned immediately; the controller shares the same reset.
- Widths: timer is $clog2(TIMEOUT) bits; starve_cnt is $clog2(MAX_STARVE+1) bits.

Decomposition:
- Into riscv_pkg:
  - arb_state_t enum {ARB_IDLE, ARB_BUSY_I, ARB_BUSY_D}.
  - ARB_MAX_STARVE and ARB_TIMEOUT defaults.
  - An arb_req_t struct {addr, wdata, be, we} for the captured request register.
- Single module; no sub-module needed. The priority/starvation logic stays inline, well under 300 lines.

Test Plan:
- dmem_rd_en=1, addr 0x100, no imem_req; bus_ack 3 cycles after bus_req with rdata 0xDEADBEEF -> bus_addr=0x100, bus_we=0; dmem_ready pulses once with dmem_rdata=0xDEADBEEF, dmem_err=0; state returns to IDLE.
- imem_req and dmem_wr_en asserted together, be=4'b0011, wdata 0x1234 -> dmem served first (bus_we=1, bus_be=0x3); imem is granted in IDLE after the dmem ack; imem_ready follows.
- imem_req held high while dmem issues 6 back-to-back reads -> grant order D,D,D,D,I,D,D; starve_cnt returns to 0 after the imem grant.
- bus_ack never asserted on an imem fetch -> imem_ready=1 and imem_err=1 exactly TIMEOUT cycles after bus_req rose; a late bus_ack afterwards produces no ready.
- reset pulled low while in BUSY_D -> bus_req=0 and all ready outputs=0 immediately (asynchronously); after release, state=IDLE and starve_cnt=0.
- dmem_rd_en and dmem_wr_en both 1 -> bus_we=1; dmem_ready pulses once.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared core types and defaults used by the memory bus arbiter.
package riscv_pkg;

  localparam int unsigned XLEN           = 32;
  localparam int unsigned ARB_MAX_STARVE = 4;
  localparam int unsigned ARB_TIMEOUT    = 64;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_BUSY_I,
    ARB_BUSY_D
  } arb_state_t;

  // Request captured at grant time and replayed on the bus until completion.
  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic [3:0]      be;
    logic            we;
  } arb_req_t;

endpackage

// File: rtl/mem_bus_arbiter.sv
// Arbitrates fetch (imem) and LSU (dmem) requests onto one memory bus.
// A single transaction is outstanding at a time; completion (ack or timeout)
// returns a one-cycle ready pulse to the owner, followed by one idle bubble.
module mem_bus_arbiter #(
  // Must match riscv_pkg::XLEN, which sizes the captured request register.
  parameter int unsigned XLEN       = riscv_pkg::XLEN,
  parameter int unsigned MAX_STARVE = riscv_pkg::ARB_MAX_STARVE,
  parameter int unsigned TIMEOUT    = riscv_pkg::ARB_TIMEOUT
) (
  input  logic            clk,
  input  logic            reset,
  // Fetch port
  input  logic            imem_req,
  input  logic [XLEN-1:0] imem_addr,
  output logic [XLEN-1:0] imem_rdata,
  output logic            imem_ready,
  output logic            imem_err,
  // LSU port
  input  logic            dmem_rd_en,
  input  logic            dmem_wr_en,
  input  logic [XLEN-1:0] dmem_addr,
  input  logic [XLEN-1:0] dmem_wdata,
  input  logic [3:0]      dmem_byte_en,
  output logic [XLEN-1:0] dmem_rdata,
  output logic            dmem_ready,
  output logic            dmem_err,
  // Memory controller side
  output logic            bus_req,
  output logic            bus_we,
  output logic [XLEN-1:0] bus_addr,
  output logic [XLEN-1:0] bus_wdata,
  output logic [3:0]      bus_be,
  input  logic            bus_ack,
  input  logic [XLEN-1:0] bus_rdata
);
  import riscv_pkg::*;

  localparam int unsigned TimerW  = $clog2(TIMEOUT);
  localparam int unsigned StarveW = $clog2(MAX_STARVE + 1);
  localparam logic [TimerW-1:0]  TimerLast = TimerW'(TIMEOUT - 1);
  localparam logic [StarveW-1:0] StarveMax = StarveW'(MAX_STARVE);

  arb_state_t          state_q, state_d;
  arb_req_t            req_q, req_d;
  logic [TimerW-1:0]   timer_q, timer_d;
  logic [StarveW-1:0]  starve_q, starve_d;

  logic dreq;
  logic grant_d;
  logic grant_i;
  logic busy;
  logic expired;

  // Arbitration: dmem (older instruction) wins unless imem has been starved too long.
  always_comb begin
    dreq    = dmem_rd_en | dmem_wr_en;
    grant_d = (state_q == ARB_IDLE) && dreq && !(imem_req && (starve_q == StarveMax));
    grant_i = (state_q == ARB_IDLE) && !grant_d && imem_req;
  end

  // Next-state: capture on grant, count busy cycles, return to idle on ack or timeout.
  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    timer_d  = timer_q;
    starve_d = starve_q;
    case (state_q)
      ARB_IDLE: begin
        timer_d = '0;
        if (grant_d) begin
          state_d     = ARB_BUSY_D;
          req_d.addr  = dmem_addr;
          req_d.wdata = dmem_wdata;
          req_d.be    = dmem_byte_en;
          // A simultaneous read and write is treated as a write.
          req_d.we    = dmem_wr_en;
          if (imem_req && (starve_q != StarveMax)) begin
            starve_d = starve_q + 1'b1;
          end
        end else if (grant_i) begin
          state_d     = ARB_BUSY_I;
          req_d.addr  = imem_addr;
          req_d.wdata = '0;
          req_d.be    = 4'hF;
          req_d.we    = 1'b0;
          starve_d    = '0;
        end
      end
      ARB_BUSY_I, ARB_BUSY_D: begin
        if (bus_ack || (timer_q == TimerLast)) begin
          state_d = ARB_IDLE;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // State registers; reset abandons any in-flight transaction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ARB_IDLE;
      req_q    <= '0;
      timer_q  <= '0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      timer_q  <= timer_d;
      starve_q <= starve_d;
    end
  end

  // Outputs: bus driven from the captured request only while busy; ready/rdata pulse on completion.
  always_comb begin
    busy      = (state_q != ARB_IDLE);
    expired   = busy && !bus_ack && (timer_q == TimerLast);
    bus_req   = busy;
    bus_we    = busy & req_q.we;
    bus_addr  = busy ? req_q.addr : '0;
    bus_wdata = busy ? req_q.wdata : '0;
    bus_be    = busy ? req_q.be : 4'h0;

    imem_ready = (state_q == ARB_BUSY_I) && (bus_ack || expired);
    imem_err   = (state_q == ARB_BUSY_I) && expired;
    imem_rdata = ((state_q == ARB_BUSY_I) && bus_ack) ? bus_rdata : '0;

    dmem_ready = (state_q == ARB_BUSY_D) && (bus_ack || expired);
    dmem_err   = (state_q == ARB_BUSY_D) && expired;
    dmem_rdata = ((state_q == ARB_BUSY_D) && bus_ack) ? bus_rdata : '0;
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios plus randomized
// transactions checked against a reference arbitration model.
module tb_mem_bus_arbiter;
  import riscv_pkg::*;

  localparam int unsigned MaxStarve = 4;
  localparam int unsigned Timeout   = 64;
  localparam int GrantNone = 0;
  localparam int GrantI    = 1;
  localparam int GrantD    = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req = 1'b0;
  logic [31:0] imem_addr = '0;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic        imem_err;
  logic        dmem_rd_en = 1'b0;
  logic        dmem_wr_en = 1'b0;
  logic [31:0] dmem_addr = '0;
  logic [31:0] dmem_wdata = '0;
  logic [3:0]  dmem_byte_en = '0;
  logic [31:0] dmem_rdata;
  logic        dmem_ready;
  logic        dmem_err;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = '0;

  int checks = 0;
  int errors = 0;
  int model_starve = 0;

  // Values observed by the bus responder during one transaction.
  logic        cap_seen;
  int          cap_wait;
  logic [31:0] cap_addr, cap_addr_ack, cap_wdata;
  logic [3:0]  cap_be;
  logic        cap_we;
  logic        cap_iready, cap_dready, cap_ierr, cap_derr;
  logic [31:0] cap_irdata, cap_drdata;

  mem_bus_arbiter #(
    .XLEN      (32),
    .MAX_STARVE(MaxStarve),
    .TIMEOUT   (Timeout)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_ready  (imem_ready),
    .imem_err    (imem_err),
    .dmem_rd_en  (dmem_rd_en),
    .dmem_wr_en  (dmem_wr_en),
    .dmem_addr   (dmem_addr),
    .dmem_wdata  (dmem_wdata),
    .dmem_byte_en(dmem_byte_en),
    .dmem_rdata  (dmem_rdata),
    .dmem_ready  (dmem_ready),
    .dmem_err    (dmem_err),
    .bus_req     (bus_req),
    .bus_we      (bus_we),
    .bus_addr    (bus_addr),
    .bus_wdata   (bus_wdata),
    .bus_be      (bus_be),
    .bus_ack     (bus_ack),
    .bus_rdata   (bus_rdata)
  );

  always #5 clk = ~clk;

  // Reference arbitration from the priority rules; tracks the starvation count.
  function automatic int model_grant(input logic ireq, input logic dreq);
    if (dreq && !(ireq && model_starve == MaxStarve)) begin
      if (ireq && model_starve < MaxStarve) model_starve++;
      return GrantD;
    end
    if (ireq) begin
      model_starve = 0;
      return GrantI;
    end
    return GrantNone;
  endfunction

  // Memory-controller responder: waits (bounded) for bus_req, acks after lat cycles.
  task automatic bus_serve(input int lat, input logic [31:0] rd);
    cap_seen = 1'b0; cap_wait = 0; cap_addr = '0; cap_addr_ack = '0; cap_wdata = '0;
    cap_be = '0; cap_we = 1'b0; cap_iready = 1'b0; cap_dready = 1'b0;
    cap_ierr = 1'b0; cap_derr = 1'b0; cap_irdata = '0; cap_drdata = '0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (bus_req) begin
        cap_seen = 1'b1;
        cap_wait = k;
        break;
      end
    end
    if (!cap_seen) return;
    cap_addr = bus_addr; cap_wdata = bus_wdata; cap_be = bus_be; cap_we = bus_we;
    for (int k = 0; k < lat; k++) begin
      @(posedge clk); #1;
    end
    bus_ack = 1'b1;
    bus_rdata = rd;
    #1;
    cap_addr_ack = bus_addr;
    cap_iready = imem_ready; cap_dready = dmem_ready;
    cap_ierr = imem_err; cap_derr = dmem_err;
    cap_irdata = imem_rdata; cap_drdata = dmem_rdata;
    @(posedge clk); #1;
    bus_ack = 1'b0;
    bus_rdata = '0;
  endtask

  task automatic test_reset();
    logic [105:0] all_out;
    bus_ack = 1'b1;
    bus_rdata = 32'hFFFF_FFFF;
    repeat (2) @(posedge clk);
    #1;
    all_out = {bus_req, bus_we, bus_be, bus_addr, bus_wdata, imem_ready, imem_err,
               dmem_ready, dmem_err, imem_rdata[7:0], dmem_rdata[7:0]};
    checks++;
    if (all_out !== '0 || imem_rdata !== '0 || dmem_rdata !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h, expected 0", all_out);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus_req !== 1'b0 || imem_ready !== 1'b0 || dmem_ready !== 1'b0) begin
      errors++;
      $display("FAIL idle_ack_ignored: req=%b iready=%b dready=%b, expected 0 0 0",
               bus_req, imem_ready, dmem_ready);
    end
    bus_ack = 1'b0;
    bus_rdata = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_single_read();
    int g;
    dmem_rd_en = 1'b1;
    dmem_addr = 32'h100;
    dmem_byte_en = 4'hF;
    g = model_grant(1'b0, 1'b1);
    checks++;
    if (bus_req !== 1'b0) begin
      errors++;
      $display("FAIL read_req_not_early: got %b, expected 0", bus_req);
    end
    bus_serve(3, 32'hDEAD_BEEF);
    dmem_rd_en = 1'b0;
    checks++;
    if (!cap_seen || cap_wait != 1 || g != GrantD) begin
      errors++;
      $display("FAIL read_latency: seen=%b wait=%0d, expected 1 1", cap_seen, cap_wait);
    end
    checks++;
    if (cap_addr !== 32'h100 || cap_we !== 1'b0) begin
      errors++;
      $display("FAIL read_bus: addr=%h we=%b, expected 00000100 0", cap_addr, cap_we);
    end
    checks++;
    if (cap_dready !== 1'b1 || cap_drdata !== 32'hDEAD_BEEF || cap_derr !== 1'b0 ||
        cap_iready !== 1'b0) begin
      errors++;
      $display("FAIL read_resp: dready=%b rdata=%h err=%b iready=%b, expected 1 deadbeef 0 0",
               cap_dready, cap_drdata, cap_derr, cap_iready);
    end
    checks++;
    if (dmem_ready !== 1'b0 || bus_req !== 1'b0 || dut.state_q !== ARB_IDLE) begin
      errors++;
      $display("FAIL read_back_idle: dready=%b req=%b state=%0d, expected 0 0 0",
               dmem_ready, bus_req, dut.state_q);
    end
  endtask

  task automatic test_write_priority();
    int g;
    imem_req = 1'b1; imem_addr = 32'h2000;
    dmem_wr_en = 1'b1; dmem_addr = 32'h300; dmem_wdata = 32'h1234; dmem_byte_en = 4'b0011;
    g = model_grant(1'b1, 1'b1);
    bus_serve(1, 32'h5555_AAAA);
    dmem_wr_en = 1'b0;
    checks++;
    if (g != GrantD || cap_dready !== 1'b1 || cap_iready !== 1'b0) begin
      errors++;
      $display("FAIL wr_first_owner: dready=%b iready=%b, expected 1 0", cap_dready, cap_iready);
    end
    checks++;
    if (cap_we !== 1'b1 || cap_be !== 4'h3 || cap_wdata !== 32'h1234 || cap_addr !== 32'h300) begin
      errors++;
      $display("FAIL wr_bus: we=%b be=%h wdata=%h addr=%h, expected 1 3 00001234 00000300",
               cap_we, cap_be, cap_wdata, cap_addr);
    end
    g = model_grant(1'b1, 1'b0);
    bus_serve(2, 32'hCAFE_F00D);
    imem_req = 1'b0;
    checks++;
    if (g != GrantI || cap_wait != 1 || cap_addr !== 32'h2000 || cap_we !== 1'b0 ||
        cap_be !== 4'hF) begin
      errors++;
      $display("FAIL fetch_bus: wait=%0d addr=%h we=%b be=%h, expected 1 00002000 0 f",
               cap_wait, cap_addr, cap_we, cap_be);
    end
    checks++;
    if (cap_iready !== 1'b1 || cap_irdata !== 32'hCAFE_F00D || cap_ierr !== 1'b0) begin
      errors++;
      $display("FAIL fetch_resp: iready=%b rdata=%h err=%b, expected 1 cafef00d 0",
               cap_iready, cap_irdata, cap_ierr);
    end
  endtask

  task automatic test_starvation();
    string order;
    int exp, got, d_done;
    order = "";
    d_done = 0;
    imem_req = 1'b1; imem_addr = 32'h4000;
    dmem_rd_en = 1'b1; dmem_addr = 32'h500; dmem_byte_en = 4'hF;
    for (int t = 0; t < 7; t++) begin
      exp = model_grant(imem_req, dmem_rd_en);
      bus_serve(int'($urandom_range(0, 2)), $urandom);
      got = cap_iready ? GrantI : (cap_dready ? GrantD : GrantNone);
      order = {order, (got == GrantI) ? "I" : ((got == GrantD) ? "D" : "-")};
      checks++;
      if (got != exp || cap_wait != 1) begin
        errors++;
        $display("FAIL starve_grant_%0d: owner=%0d wait=%0d, expected %0d 1", t, got, cap_wait, exp);
      end
      if (got == GrantI) begin
        imem_req = 1'b0;
        checks++;
        if (int'(dut.starve_q) != 0) begin
          errors++;
          $display("FAIL starve_cleared: got %0d, expected 0", dut.starve_q);
        end
      end
      if (got == GrantD) d_done++;
      if (d_done == 6) dmem_rd_en = 1'b0;
    end
    dmem_rd_en = 1'b0;
    imem_req = 1'b0;
    checks++;
    if (order != "DDDDIDD") begin
      errors++;
      $display("FAIL starve_order: got %s, expected DDDDIDD", order);
    end
  endtask

  task automatic test_timeout();
    int g, n;
    logic seen;
    imem_req = 1'b1; imem_addr = 32'h6000;
    g = model_grant(1'b1, 1'b0);
    bus_rdata = 32'hFFFF_FFFF;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (bus_req) begin
        seen = 1'b1;
        break;
      end
    end
    n = 1;
    while (seen && !imem_ready && n < int'(Timeout) + 10) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (!seen || g != GrantI || n != int'(Timeout)) begin
      errors++;
      $display("FAIL timeout_cycles: got %0d, expected %0d", n, Timeout);
    end
    checks++;
    if (imem_ready !== 1'b1 || imem_err !== 1'b1 || imem_rdata !== '0 || dmem_ready !== 1'b0) begin
      errors++;
      $display("FAIL timeout_resp: ready=%b err=%b rdata=%h dready=%b, expected 1 1 0 0",
               imem_ready, imem_err, imem_rdata, dmem_ready);
    end
    imem_req = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus_req !== 1'b0) begin
      errors++;
      $display("FAIL timeout_drop_req: got %b, expected 0", bus_req);
    end
    bus_ack = 1'b1;
    #1;
    checks++;
    if (imem_ready !== 1'b0 || dmem_ready !== 1'b0) begin
      errors++;
      $display("FAIL late_ack: iready=%b dready=%b, expected 0 0", imem_ready, dmem_ready);
    end
    @(posedge clk); #1;
    bus_ack = 1'b0;
    bus_rdata = '0;
    checks++;
    if (bus_req !== 1'b0) begin
      errors++;
      $display("FAIL late_ack_no_txn: got %b, expected 0", bus_req);
    end
  endtask

  task automatic test_reset_mid();
    int g;
    logic seen;
    imem_req = 1'b1; imem_addr = 32'h7000;
    dmem_rd_en = 1'b1; dmem_addr = 32'h800;
    g = model_grant(1'b1, 1'b1);
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (bus_req) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen || g != GrantD || int'(dut.starve_q) != model_starve) begin
      errors++;
      $display("FAIL midrst_pre_starve: got %0d, expected %0d", dut.starve_q, model_starve);
    end
    #2;
    bus_ack = 1'b1;
    bus_rdata = 32'h1357_9BDF;
    reset = 1'b0;
    #1;
    checks++;
    if (bus_req !== 1'b0 || dmem_ready !== 1'b0 || imem_ready !== 1'b0 ||
        dmem_rdata !== '0 || bus_addr !== '0) begin
      errors++;
      $display("FAIL midrst_async: req=%b dready=%b iready=%b rdata=%h addr=%h, expected all 0",
               bus_req, dmem_ready, imem_ready, dmem_rdata, bus_addr);
    end
    imem_req = 1'b0;
    dmem_rd_en = 1'b0;
    bus_ack = 1'b0;
    bus_rdata = '0;
    model_starve = 0;
    #3 reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (dut.state_q !== ARB_IDLE || int'(dut.starve_q) != 0 || bus_req !== 1'b0) begin
      errors++;
      $display("FAIL midrst_after: state=%0d starve=%0d req=%b, expected 0 0 0",
               dut.state_q, dut.starve_q, bus_req);
    end
  endtask

  task automatic test_rw_both();
    int g;
    dmem_rd_en = 1'b1; dmem_wr_en = 1'b1;
    dmem_addr = 32'h900; dmem_wdata = 32'hA5A5; dmem_byte_en = 4'b1100;
    g = model_grant(1'b0, 1'b1);
    bus_serve(0, 32'h0BAD_0BAD);
    dmem_rd_en = 1'b0; dmem_wr_en = 1'b0;
    checks++;
    if (g != GrantD || cap_we !== 1'b1 || cap_be !== 4'hC || cap_wdata !== 32'hA5A5 ||
        cap_dready !== 1'b1) begin
      errors++;
      $display("FAIL rw_both: we=%b be=%h wdata=%h dready=%b, expected 1 c 0000a5a5 1",
               cap_we, cap_be, cap_wdata, cap_dready);
    end
    @(posedge clk); #1;
    checks++;
    if (dmem_ready !== 1'b0) begin
      errors++;
      $display("FAIL rw_single_pulse: got %b, expected 0", dmem_ready);
    end
  endtask

  task automatic test_random();
    logic        ireq, drd, dwr;
    logic [31:0] ia, da, dw, rd, exp_addr;
    logic [3:0]  be;
    int          exp;
    for (int it = 0; it < 40; it++) begin
      ireq = ($urandom_range(0, 3) != 0);
      drd  = 1'($urandom_range(0, 1));
      dwr  = 1'($urandom_range(0, 1));
      if (!ireq && !drd && !dwr) drd = 1'b1;
      ia = $urandom & 32'hFFFF_FFFC;
      da = $urandom;
      dw = $urandom;
      be = 4'($urandom);
      rd = $urandom;
      exp = model_grant(ireq, drd | dwr);
      exp_addr = (exp == GrantI) ? ia : da;
      imem_req = ireq; imem_addr = ia;
      dmem_rd_en = drd; dmem_wr_en = dwr; dmem_addr = da; dmem_wdata = dw; dmem_byte_en = be;
      bus_serve(int'($urandom_range(0, 4)), rd);
      imem_req = 1'b0; dmem_rd_en = 1'b0; dmem_wr_en = 1'b0;
      checks++;
      if (!cap_seen || cap_wait != 1 || cap_addr !== exp_addr || cap_addr_ack !== exp_addr) begin
        errors++;
        $display("FAIL rand_addr_%0d: wait=%0d addr=%h at_ack=%h, expected 1 %h",
                 it, cap_wait, cap_addr, cap_addr_ack, exp_addr);
      end
      if (exp == GrantI) begin
        checks++;
        if (cap_we !== 1'b0 || cap_be !== 4'hF || cap_iready !== 1'b1 || cap_dready !== 1'b0 ||
            cap_irdata !== rd || cap_ierr !== 1'b0) begin
          errors++;
          $display("FAIL rand_fetch_%0d: we=%b be=%h iready=%b dready=%b rdata=%h, expected 0 f 1 0 %h",
                   it, cap_we, cap_be, cap_iready, cap_dready, cap_irdata, rd);
        end
      end else begin
        checks++;
        if (cap_we !== dwr || cap_be !== be || cap_wdata !== dw || cap_dready !== 1'b1 ||
            cap_iready !== 1'b0 || cap_drdata !== rd || cap_derr !== 1'b0) begin
          errors++;
          $display("FAIL rand_lsu_%0d: we=%b be=%h wdata=%h dready=%b iready=%b rdata=%h, expected %b %h %h 1 0 %h",
                   it, cap_we, cap_be, cap_wdata, cap_dready, cap_iready, cap_drdata,
                   dwr, be, dw, rd);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write_priority();
    test_starvation();
    test_timeout();
    test_reset_mid();
    test_rw_both();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
